fnd_scan_ctrl: RTL and testbench
================================

# fnd_scan_ctrl

Self-scanning, parametrised FND (7-segment) display controller; successor to the fixed 4-digit combinational FND driver. Accepts a binary value through a valid pulse, converts it to BCD sequentially (shift-add-3), and holds it in a display register. It then time-multiplexes N digits with its own scan prescaler, driving active-low segment and common lines. It sits between the counter/datapath and the board FND pins.

## Interface
- N_DIGITS, 4, number of digits scanned; legal 1..8.
- IN_W, 14, binary input width; legal 1..27.
- CLK_HZ, 100_000_000, clk frequency.
- SCAN_HZ, 1000, digit-advance rate; CLK_HZ/SCAN_HZ must be ≥ 2.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  IN_W  unsigned binary value to display.
- in_valid  input  1  single-cycle load strobe; sampled only in IDLE.
- dp_sel  input  N_DIGITS  live, not latched; bit i=1 lights the decimal point of digit i.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  high when the currently displayed value was saturated.
- fnd_com  output  N_DIGITS  active-low digit enables, one-hot-low.
- fnd_data  output  8  active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- Conversion FSM states:
  - IDLE: in_valid=1 latches in_val into shift register, loads BCD accumulator (4·N_DIGITS bits) with 0, computes overflow_next = (in_val > 10^N_DIGITS−1) in 32-bit arithmetic, then goes to SHIFT.
  - SHIFT: exactly IN_W cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts {bcd,bin} left 1. Bits shifted out of the top nibble are discarded.
  - COMMIT: one cycle. The display register takes the BCD accumulator, or all nibbles = 9 if overflow_next. overflow takes overflow_next. Then goes to IDLE.
- in_valid in SHIFT/COMMIT is ignored and not queued.
- Display register updates atomically, only in COMMIT; the scan never shows a half-converted value.
- Scan prescaler counts 0..CLK_HZ/SCAN_HZ−1. At terminal count it wraps to 0 and pulses tick.
- Digit index idx advances on tick: 0→1→…→N_DIGITS−1→0.
- fnd_com = ~(1<<idx).
- Segment encoding for nibble 0..9: C0,F9,A4,B0,99,92,82,F8,80,90. Nibbles 10..15 and blanked digits give FF.
- fnd_data[7] is cleared when dp_sel[idx]=1, including on blanked digits.
- fnd_com and fnd_data are registered and update together on the edge after tick.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, overflow=0, display register=0, prescaler=0, idx=0.
  - fnd_com = all ones except bit0=0; fnd_data=8'hC0.
- Reset asserted mid-conversion aborts it; display returns to 0 asynchronously.
- Conversion latency: in_valid sampled at edge k → busy=1 after edge k. SHIFT covers edges k+1..k+IN_W, COMMIT at edge k+IN_W+1. New display, overflow and busy=0 are visible after edge k+IN_W+1.
- Latency is fixed and independent of the value, including the overflow case.
- in_valid at the same edge that returns the FSM to IDLE is ignored; the next acceptable edge is k+IN_W+2.
- Digit dwell is CLK_HZ/SCAN_HZ cycles; full frame is N_DIGITS× that.
- Display update and tick on the same edge: the new digit shows new data.

## Configuration
- FND_LZ_BLANK_EN defined: leading-zero blanking. A digit i>0 whose nibble and all higher nibbles are 0 drives fnd_data=FF, with dp still honoured. Digit 0 is never blanked, so value 0 shows "0".
- Undefined: all N_DIGITS digits always show their nibble, e.g. 0042 shows as "0042".

## Test plan
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (dwell 10 cycles), N_DIGITS=4, IN_W=14.
- Reset, then observe 40 cycles.
  - fnd_com cycles E,D,B,7 every 10 cycles.
  - fnd_data=C0 on every digit, or C0 on digit 0 and FF elsewhere with FND_LZ_BLANK_EN defined.
  - busy=0 throughout.
- in_val=1234, pulse in_valid.
  - busy high for exactly 15 cycles.
  - Digits 0..3 then show 99,B0,A4,F9.
  - overflow=0.
- in_val=12000 (>9999).
  - After 15 cycles all digits show 90; overflow=1.
  - Then in_val=5 clears overflow; display shows 92 on digit 0.
- in_valid pulsed again 3 cycles into a conversion of 42 with in_val=7777.
  - Second pulse ignored; display shows 42.
  - With FND_LZ_BLANK_EN, digits 2..3 show FF.
- dp_sel=4'b0100 with value 1234.
  - Digit 2 shows 24 and all others are unchanged.
  - Toggling dp_sel takes effect on the next registered update.
- reset asserted at cycle 5 of a conversion of 9999.
  - Outputs immediately return to reset values and busy=0.
  - The display never shows 9999.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
//
// Self-scanning 7-segment (FND) display controller.
//
// A binary value is loaded with a one-cycle strobe and converted to BCD
// sequentially using shift-add-3 (double dabble). The result is committed
// atomically to a display register. The controller then time-multiplexes
// N_DIGITS digits using its own scan prescaler. It drives active-low
// segment and common lines.
//
// Optional feature macro: FND_LZ_BLANK_EN
//   defined   : leading-zero blanking. Digit 0 is never blanked, and the
//               decimal point is still honoured on blanked digits.
//   undefined : every digit always shows its nibble.
//
// Parameters
//   N_DIGITS : digits scanned (1..8)
//   IN_W     : binary input width (1..27)
//   CLK_HZ   : clk frequency
//   SCAN_HZ  : digit-advance rate (CLK_HZ/SCAN_HZ >= 2)
//
// Ports
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous active-high reset
//   in_val    in   IN_W      unsigned binary value to display
//   in_valid  in   1         load strobe, honoured only while idle
//   dp_sel    in   N_DIGITS  live decimal-point select, bit i -> digit i
//   busy      out  1         conversion in progress
//   overflow  out  1         displayed value was saturated to all nines
//   fnd_com   out  N_DIGITS  active-low digit enables (one-hot-low)
//   fnd_data  out  8         active-low segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module fnd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int IN_W     = 14,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_W-1:0]     in_val,
  input  logic                in_valid,
  input  logic [N_DIGITS-1:0] dp_sel,
  output logic                busy,
  output logic                overflow,
  output logic [N_DIGITS-1:0] fnd_com,
  output logic [7:0]          fnd_data
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int BCD_W = 4 * N_DIGITS;

  // Largest value representable in N_DIGITS decimal digits, 10^N - 1.
  // This is evaluated in 32 bits, which holds up to 10^8 - 1 and any 27-bit input.
  function automatic logic [31:0] max_decimal(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

  localparam logic [31:0]      MAX_VAL = max_decimal(N_DIGITS);
  localparam logic [BCD_W-1:0] NINES   = {N_DIGITS{4'h9}};

  // Active-low segment pattern for one nibble. The dp bit is left high here
  // and overridden later from dp_sel.
  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Conversion state
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_reg;
  logic [IN_W-1:0]    bin_reg;       // binary shift register
  logic [BCD_W-1:0]   bcd_reg;       // BCD accumulator
  logic [CNT_W-1:0]   cnt_reg;       // remaining SHIFT cycles minus one
  logic               ovf_pend_reg;  // saturation decision for the pending value
  logic [BCD_W-1:0]   disp_reg;      // value currently on the display
  logic               overflow_reg;
  logic               busy_reg;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [IN_W-1:0]    bin_shift;
  logic [BCD_W-1:0]   disp_next;
  logic               ovf_in;

  // Add 3 to every nibble that is 5 or more, so the following shift carries
  // correctly into the next decade.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                (bcd_reg[4*gi +: 4] + 4'd3) :
                                bcd_reg[4*gi +: 4];
  end

  // Shift {bcd,bin} left by one. Anything leaving the top nibble is lost,
  // which only happens for values that are saturated anyway.
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[IN_W-1]};
  assign bin_shift = bin_reg << 1;

  assign ovf_in = (32'(in_val) > MAX_VAL);

  // The display register changes only in COMMIT. The scan path below reads
  // this look-ahead value, so a commit landing on a tick edge already shows
  // the new digit.
  always_comb begin
    disp_next = disp_reg;
    if (state_reg == COMMIT) begin
      disp_next = ovf_pend_reg ? NINES : bcd_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      disp_reg     <= '0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      disp_reg <= disp_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg      <= in_val;
            bcd_reg      <= '0;
            cnt_reg      <= CNT_W'(IN_W - 1);
            ovf_pend_reg <= ovf_in;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          // The number of cycles is fixed at IN_W regardless of the value,
          // so the latency is identical for saturated inputs.
          bcd_reg <= bcd_shift;
          bin_reg <= bin_shift;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == '0) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          overflow_reg <= ovf_pend_reg;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Scan prescaler and digit index
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  logic             tick;

  assign tick = (pre_reg == PRE_W'(DIV - 1));

  always_comb begin
    idx_next = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Digit data selection
  // -------------------------------------------------------------------------
  logic [3:0]          nib_next [N_DIGITS];
  logic [N_DIGITS-1:0] blank;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
    assign nib_next[gi] = disp_next[4*gi +: 4];
  end

`ifdef FND_LZ_BLANK_EN
  // Digit i is blanked when it and every more significant nibble are zero.
  // Digit 0 always shows, so the value 0 reads as "0".
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_first
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = (disp_next[BCD_W-1:4*gi] == '0);
    end
  end
`else
  assign blank = '0;
`endif

  logic [7:0]          seg_next;
  logic [7:0]          data_next;
  logic [N_DIGITS-1:0] com_next;

  always_comb begin
    seg_next  = blank[idx_next] ? 8'hFF : seg7(nib_next[idx_next]);
    // dp_sel is sampled live every cycle and also applies to blanked digits.
    data_next = {~dp_sel[idx_next], seg_next[6:0]};
    com_next  = ~(N_DIGITS'(1) << idx_next);
  end

  logic [N_DIGITS-1:0] fnd_com_reg;
  logic [7:0]          fnd_data_reg;

  // Common and segment lines are registered from the same look-ahead
  // index, so they always change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_reg      <= '0;
      idx_reg      <= '0;
      fnd_com_reg  <= ~N_DIGITS'(1);
      fnd_data_reg <= 8'hC0;
    end else begin
      pre_reg      <= tick ? '0 : pre_reg + PRE_W'(1);
      idx_reg      <= idx_next;
      fnd_com_reg  <= com_next;
      fnd_data_reg <= data_next;
    end
  end

  assign busy     = busy_reg;
  assign overflow = overflow_reg;
  assign fnd_com  = fnd_com_reg;
  assign fnd_data = fnd_data_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_ctrl
//
// Scoreboard bench for fnd_scan_ctrl (N_DIGITS=4, IN_W=14, dwell of 10 cycles).
//
// The stimulus process queues the expected display for each action:
//   - a conversion, which is detected when busy falls; or
//   - a probe, for dp_sel changes and the reset state.
// The monitor pops each entry when the event occurs. It then samples one
// full 40-cycle frame and compares the segment byte, dwell and busy of
// every digit. Reset snapshots go through a second queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fnd_scan_ctrl;

  localparam int N_DIGITS = 4;
  localparam int IN_W     = 14;
  localparam int CLK_HZ   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int DWELL    = 10;
  localparam int FRAME    = 40;

`ifdef FND_LZ_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;  // leading zero digit is blanked
`else
  localparam logic [7:0] LZ = 8'hC0;  // leading zero digit shows "0"
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [IN_W-1:0]     in_val = '0;
  logic                in_valid = 1'b0;
  logic [N_DIGITS-1:0] dp_sel = '0;
  logic                busy;
  logic                overflow;
  logic [N_DIGITS-1:0] fnd_com;
  logic [7:0]          fnd_data;

  fnd_scan_ctrl #(
    .N_DIGITS(N_DIGITS),
    .IN_W    (IN_W),
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_valid(in_valid),
    .dp_sel  (dp_sel),
    .busy    (busy),
    .overflow(overflow),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] segs;      // {digit3,digit2,digit1,digit0}
    logic        ovf;
    bit          chk_busy;  // event is a busy fall: check its length
    int          busy_len;
  } exp_t;

  typedef struct {
    logic       busy;
    logic       ovf;
    logic [3:0] com;
    logic [7:0] data;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snap_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    probe_cnt = 0;
  int    frames_done = 0;
  int    nf = 0;

  function automatic exp_t mk(input string name, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0, input logic ovf,
                              input bit chk_busy, input int busy_len);
    exp_t e;
    e.name     = name;
    e.segs     = {d3, d2, d1, d0};
    e.ovf      = ovf;
    e.chk_busy = chk_busy;
    e.busy_len = busy_len;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    exp_t       e;
    snap_t      s;
    bit         busy_prev;
    int         busy_run;
    int         probe_seen;
    logic [7:0] act [4];
    int         cnt [4];
    int         bad;
    int         k;
    logic       busy_seen;
    busy_prev  = 1'b0;
    busy_run   = 0;
    probe_seen = 0;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk("rst_busy", 32'(s.busy), 32'h0);
        chk("rst_overflow", 32'(s.ovf), 32'h0);
        chk("rst_fnd_com", 32'(s.com), 32'hE);
        chk("rst_fnd_data", 32'(s.data), 32'hC0);
      end
      if (busy === 1'b1 && !busy_prev) busy_run = 0;
      if (busy === 1'b1) busy_run++;
      if ((busy_prev && busy === 1'b0) || (probe_cnt != probe_seen)) begin
        probe_seen = probe_cnt;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: busy=%0b with empty scoreboard", busy);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_busy) chk({e.name, "_busy_len"}, 32'(busy_run), 32'(e.busy_len));
          chk({e.name, "_overflow"}, 32'(overflow), 32'(e.ovf));
          for (int d = 0; d < 4; d++) begin
            act[d] = e.segs[8*d +: 8];
            cnt[d] = 0;
          end
          bad = 0;
          busy_seen = 1'b0;
          for (int t = 0; t < FRAME; t++) begin
            if (t > 0) @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
            case (fnd_com)
              4'hE:    k = 0;
              4'hD:    k = 1;
              4'hB:    k = 2;
              4'h7:    k = 3;
              default: k = -1;
            endcase
            if (k < 0) begin
              bad++;
            end else begin
              cnt[k]++;
              if (fnd_data !== e.segs[8*k +: 8]) act[k] = fnd_data;
            end
          end
          chk({e.name, "_com_invalid"}, 32'(bad), 32'h0);
          chk({e.name, "_busy_in_frame"}, 32'(busy_seen), 32'h0);
          for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_seg_d%0d", e.name, d), 32'(act[d]), 32'(e.segs[8*d +: 8]));
            chk($sformatf("%s_dwell_d%0d", e.name, d), 32'(cnt[d]), 32'(DWELL));
          end
        end
        frames_done++;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic wait_frame(input int n);
    int waited;
    waited = 0;
    while (frames_done < n) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        $display("FAIL wait_frame: frames_done=%0d required=%0d", frames_done, n);
        $fatal(1, "scoreboard event never arrived");
      end
    end
  endtask

  task automatic load(input int v);
    @(negedge clk);
    in_val   = IN_W'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic conv(input int v, input exp_t e);
    exp_q.push_back(e);
    load(v);
    nf++;
    wait_frame(nf);
  endtask

  task automatic probe(input exp_t e);
    @(negedge clk);
    #1;
    exp_q.push_back(e);
    probe_cnt++;
    nf++;
    wait_frame(nf);
  endtask

  task automatic snapshot();
    snap_t s;
    s.busy = busy;
    s.ovf  = overflow;
    s.com  = fnd_com;
    s.data = fnd_data;
    snap_q.push_back(s);
  endtask

  initial begin : stim
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 snapshot();
    @(posedge clk);
    #2 reset = 1'b0;
    probe(mk("reset", LZ, LZ, LZ, 8'hC0, 1'b0, 0, 0));

    conv(1234,  mk("v1234",  8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0, 1, 15));
    conv(12000, mk("v12000", 8'h90, 8'h90, 8'h90, 8'h90, 1'b1, 1, 15));
    conv(9999,  mk("v9999",  8'h90, 8'h90, 8'h90, 8'h90, 1'b0, 1, 15));
    conv(10000, mk("v10000", 8'h90, 8'h90, 8'h90, 8'h90, 1'b1, 1, 15));
    conv(5,     mk("v5",     LZ, LZ, LZ, 8'h92, 1'b0, 1, 15));

    // The decimal point is still lit on a leading-zero digit.
    dp_sel = 4'b1000;
    probe(mk("dp3_v5", LZ & 8'h7F, LZ, LZ, 8'h92, 1'b0, 0, 0));
    dp_sel = 4'b0000;

    // A second strobe three cycles into a conversion is ignored.
    exp_q.push_back(mk("dbl42", LZ, LZ, 8'h99, 8'hA4, 1'b0, 1, 15));
    load(42);
    repeat (2) @(posedge clk);
    load(7777);
    nf++;
    wait_frame(nf);

    // A strobe on the COMMIT edge (k+15) is ignored as well.
    exp_q.push_back(mk("commit_edge", 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0, 1, 15));
    load(1234);
    repeat (14) @(posedge clk);
    load(8);
    nf++;
    wait_frame(nf);

    dp_sel = 4'b0100;
    repeat (2) @(posedge clk);
    probe(mk("dp2_on", 8'hF9, 8'h24, 8'hB0, 8'h99, 1'b0, 0, 0));
    dp_sel = 4'b0000;
    repeat (2) @(posedge clk);
    probe(mk("dp2_off", 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0, 0, 0));

    // Reset five cycles into a conversion of 9999.
    exp_q.push_back(mk("abort", LZ, LZ, LZ, 8'hC0, 1'b0, 1, 5));
    load(9999);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 snapshot();
    #1 reset = 1'b0;
    nf++;
    wait_frame(nf);

    conv(7, mk("v7_after_rst", LZ, LZ, LZ, 8'hF8, 1'b0, 1, 15));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
